// File: rtl/alu_div_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_div_share_arbiter
//
// Shares one multi-cycle 64-bit divider between two requesters. A round-robin
// arbiter picks one request while idle, latches its operands, starts the
// divider, waits for its result (guarded by a watchdog), and presents the
// result on a valid/ready response port tagged with the requester index and
// the requester's transaction tag. Only one operation is in flight at a time.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   flush                    synchronous abort of any queued/in-flight op
//   reqN_valid/ready         request handshake per requester (N = 0, 1)
//   reqN_numA/numB           dividend / divisor
//   reqN_func                [1] 0=quotient 1=remainder, [0] 0=unsigned 1=signed
//   reqN_tag                 echoed on resp_tag
//   resp_valid/ready         response handshake
//   resp_data/err/src/tag    result, error flag, requester index, tag
//   div_start/clean          one-cycle start / abort pulses to the divider
//   div_numA/numB/func       divider operands (held from the operand registers)
//   div_numC/ready/err       divider result, completion strobe, error flag
// -----------------------------------------------------------------------------
module alu_div_share_arbiter #(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_numA,
    input  logic [63:0]      req0_numB,
    input  logic [1:0]       req0_func,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_numA,
    input  logic [63:0]      req1_numB,
    input  logic [1:0]       req1_func,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic             resp_err,
    output logic             resp_src,
    output logic [TAG_W-1:0] resp_tag,
    output logic             div_start,
    output logic             div_clean,
    output logic [63:0]      div_numA,
    output logic [63:0]      div_numB,
    output logic [1:0]       div_func,
    input  logic [63:0]      div_numC,
    input  logic             div_ready,
    input  logic             div_err
);

    localparam int unsigned     WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_ZERO  = {WD_W{1'b0}};
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
    // Watchdog value on the last permitted BUSY cycle (count starts at 0).
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [63:0]     ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [63:0]      op_numA_q, op_numA_d;
    logic [63:0]      op_numB_q, op_numB_d;
    logic [1:0]       op_func_q, op_func_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;
    logic             op_src_q, op_src_d;
    logic             resp_valid_q, resp_valid_d;
    logic [63:0]      resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_src_q, resp_src_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic             div_start_q, div_start_d;
    logic             div_clean_q, div_clean_d;

    logic             gnt_any_s;
    logic             gnt_idx_s;
    logic [63:0]      sel_numA_s;
    logic [63:0]      sel_numB_s;
    logic [1:0]       sel_func_s;
    logic [TAG_W-1:0] sel_tag_s;
    logic             req0_ready_s;
    logic             req1_ready_s;

    // Round-robin choice; the pointer only matters when both requesters are valid.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_any_s = 1'b1;
            gnt_idx_s = rr_q;
        end else if (req0_valid) begin
            gnt_any_s = 1'b1;
            gnt_idx_s = 1'b0;
        end else if (req1_valid) begin
            gnt_any_s = 1'b1;
            gnt_idx_s = 1'b1;
        end else begin
            gnt_any_s = 1'b0;
            gnt_idx_s = 1'b0;
        end
    end

    assign sel_numA_s = gnt_idx_s ? req1_numA : req0_numA;
    assign sel_numB_s = gnt_idx_s ? req1_numB : req0_numB;
    assign sel_func_s = gnt_idx_s ? req1_func : req0_func;
    assign sel_tag_s  = gnt_idx_s ? req1_tag  : req0_tag;

    // Next-state, operand capture, response capture and divider pulse requests.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        wd_d         = wd_q;
        op_numA_d    = op_numA_q;
        op_numB_d    = op_numB_q;
        op_func_d    = op_func_q;
        op_tag_d     = op_tag_q;
        op_src_d     = op_src_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        resp_src_d   = resp_src_q;
        resp_tag_d   = resp_tag_q;
        div_start_d  = 1'b0;
        div_clean_d  = 1'b0;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;

        if (flush) begin
            // Abort wins over any grant or handshake; the divider is only
            // told to clean up if it was actually started.
            state_d = IDLE;
            if ((state_q == ISSUE) || (state_q == BUSY)) begin
                div_clean_d = 1'b1;
            end else begin
                div_clean_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any_s) begin
                        // Ready is masked while reset is asserted so that no
                        // request is seen as accepted during reset.
                        req0_ready_s = ~gnt_idx_s & rst;
                        req1_ready_s = gnt_idx_s & rst;
                        rr_d         = ~gnt_idx_s;
                        op_numA_d    = sel_numA_s;
                        op_numB_d    = sel_numB_s;
                        op_func_d    = sel_func_s;
                        op_tag_d     = sel_tag_s;
                        op_src_d     = gnt_idx_s;
                        if (sel_numB_s == 64'd0) begin
                            // Division by zero is answered locally.
                            state_d     = HOLD;
                            resp_data_d = ALL_ONES;
                            resp_err_d  = 1'b1;
                            resp_src_d  = gnt_idx_s;
                            resp_tag_d  = sel_tag_s;
                        end else begin
                            state_d     = ISSUE;
                            div_start_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ISSUE: begin
                    state_d = BUSY;
                    wd_d    = WD_ZERO;
                end
                BUSY: begin
                    // wd_q == 0 marks the first BUSY cycle, where div_ready may
                    // still reflect the divider's previous state.
                    if ((wd_q != WD_ZERO) && div_ready) begin
                        state_d     = HOLD;
                        resp_data_d = div_numC;
                        resp_err_d  = div_err;
                        resp_src_d  = op_src_q;
                        resp_tag_d  = op_tag_q;
                    end else if (wd_q == WD_LAST) begin
                        state_d     = HOLD;
                        div_clean_d = 1'b1;
                        resp_data_d = ALL_ONES;
                        resp_err_d  = 1'b1;
                        resp_src_d  = op_src_q;
                        resp_tag_d  = op_tag_q;
                    end else begin
                        wd_d = wd_q + WD_ONE;
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        resp_valid_d = (state_d == HOLD);
    end

    // State, operand and registered-output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            wd_q         <= WD_ZERO;
            op_numA_q    <= 64'd0;
            op_numB_q    <= 64'd0;
            op_func_q    <= 2'd0;
            op_tag_q     <= {TAG_W{1'b0}};
            op_src_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 64'd0;
            resp_err_q   <= 1'b0;
            resp_src_q   <= 1'b0;
            resp_tag_q   <= {TAG_W{1'b0}};
            div_start_q  <= 1'b0;
            div_clean_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            wd_q         <= wd_d;
            op_numA_q    <= op_numA_d;
            op_numB_q    <= op_numB_d;
            op_func_q    <= op_func_d;
            op_tag_q     <= op_tag_d;
            op_src_q     <= op_src_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_src_q   <= resp_src_d;
            resp_tag_q   <= resp_tag_d;
            div_start_q  <= div_start_d;
            div_clean_q  <= div_clean_d;
        end
    end

    assign req0_ready = req0_ready_s;
    assign req1_ready = req1_ready_s;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign resp_src   = resp_src_q;
    assign resp_tag   = resp_tag_q;
    assign div_start  = div_start_q;
    assign div_clean  = div_clean_q;
    assign div_numA   = op_numA_q;
    assign div_numB   = op_numB_q;
    assign div_func   = op_func_q;

endmodule

// File: tb/tb_alu_div_share_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for alu_div_share_arbiter: a behavioural divider model answers the
// DUT's divider port; a negedge monitor predicts grants and responses from
// the arbitration rules and compares them against a scoreboard queue filled
// at request acceptance.
// -----------------------------------------------------------------------------
module tb_alu_div_share_arbiter;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 31;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst, flush;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_numA, req0_numB, req1_numA, req1_numB;
    logic [1:0]  req0_func, req1_func;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic resp_valid, resp_ready, resp_err, resp_src;
    logic [63:0] resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic div_start, div_clean, div_ready, div_err;
    logic [63:0] div_numA, div_numB, div_numC;
    logic [1:0]  div_func;

    always #5 clk = ~clk;

    alu_div_share_arbiter #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_numA(req0_numA),
        .req0_numB(req0_numB), .req0_func(req0_func), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_numA(req1_numA),
        .req1_numB(req1_numB), .req1_func(req1_func), .req1_tag(req1_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .resp_src(resp_src), .resp_tag(resp_tag),
        .div_start(div_start), .div_clean(div_clean), .div_numA(div_numA),
        .div_numB(div_numB), .div_func(div_func), .div_numC(div_numC),
        .div_ready(div_ready), .div_err(div_err));

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference division. The bench divider flags err when both operand LSBs
    // are 1, purely to exercise error pass-through.
    function automatic logic [64:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] f);
        logic [63:0] q, r;
        logic signed [63:0] sa, sb;
        if (b == 64'd0) return {1'b1, ALL1};
        if (f[0]) begin
            sa = a; sb = b;
            if (a == 64'h8000_0000_0000_0000 && b == ALL1) begin
                q = a; r = 64'd0;
            end else begin
                q = sa / sb; r = sa % sb;
            end
        end else begin
            q = a / b; r = a % b;
        end
        return {a[0] & b[0], f[1] ? r : q};
    endfunction

    // ---------------- divider model ----------------
    bit stuck = 1'b0;   // never report completion
    bit lat0  = 1'b0;   // report completion only in the first BUSY cycle
    logic dv_busy;
    logic [3:0] dv_cnt;
    logic [63:0] dv_a, dv_b;
    logic [1:0] dv_f;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_busy <= 1'b0; dv_cnt <= 4'd0; dv_a <= 64'd0; dv_b <= 64'd0; dv_f <= 2'd0;
        end else if (div_clean) begin
            dv_busy <= 1'b0;
        end else if (div_start) begin
            dv_busy <= !stuck;
            dv_cnt  <= lat0 ? 4'd0 : 4'($urandom_range(10, 1));
            dv_a <= div_numA; dv_b <= div_numB; dv_f <= div_func;
        end else if (dv_busy) begin
            if (dv_cnt == 4'd0) dv_busy <= 1'b0;
            else dv_cnt <= dv_cnt - 4'd1;
        end
    end
    assign div_ready = dv_busy && (dv_cnt == 4'd0);
    assign {div_err, div_numC} = ref_div(dv_a, dv_b, dv_f);

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [63:0] a, b;
        logic [1:0] f;
        logic src;
        logic [TAG_W-1:0] tag;
        logic [63:0] data;
        logic err;
    } exp_t;
    exp_t sbq[$];
    bit   gl[$];             // DUT grant order
    bit   mbusy = 1'b0, ptr = 1'b0, zero_chk = 1'b0, rv_prev = 1'b0;
    bit   expect_to = 1'b0;
    bit   acc0 = 1'b0, acc1 = 1'b0;
    int   start_cnt = 0, starts_exp = 0, clean_cnt = 0, start_cyc = 0, valid_cyc = 0;
    logic [69:0] last_resp = 70'd0;

    initial begin
        bit e0, e1, g;
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sbq.delete(); mbusy = 1'b0; ptr = 1'b0; zero_chk = 1'b0; rv_prev = 1'b0;
            end else begin
                e0 = !mbusy && !flush && req0_valid && (!req1_valid || !ptr);
                e1 = !mbusy && !flush && req1_valid && (!req0_valid || ptr);
                chk("ready", {req0_ready, req1_ready}, {e0, e1});
                if (req0_ready && req0_valid) begin acc0 = 1'b1; gl.push_back(1'b0); end
                if (req1_ready && req1_valid) begin acc1 = 1'b1; gl.push_back(1'b1); end
                if (div_start) begin
                    start_cnt++;
                    start_cyc = cyc;
                    if (sbq.size() == 0) chk("div_start_unexp", div_start, 1'b0);
                    else chk("div_ops", {div_numA, div_numB, div_func}, {sbq[0].a, sbq[0].b, sbq[0].f});
                end
                if (div_clean) clean_cnt++;
                if (zero_chk) begin chk("zero_latency", resp_valid, 1'b1); zero_chk = 1'b0; end
                if (resp_valid && !rv_prev) valid_cyc = cyc;
                rv_prev = resp_valid;
                if (sbq.size() == 0) chk("spurious_resp", resp_valid, 1'b0);
                else if (resp_valid)
                    chk("resp", {resp_data, resp_err, resp_src, resp_tag},
                        {sbq[0].data, sbq[0].err, sbq[0].src, sbq[0].tag});

                if (flush) begin
                    if (sbq.size() > 0) sbq.delete(0);
                    mbusy = 1'b0;
                end else if (resp_valid && resp_ready && sbq.size() > 0) begin
                    last_resp = {resp_data, resp_err, resp_src, resp_tag};
                    sbq.delete(0);
                    mbusy = 1'b0;
                end else if (e0 || e1) begin
                    g = e1;
                    x.a = g ? req1_numA : req0_numA;
                    x.b = g ? req1_numB : req0_numB;
                    x.f = g ? req1_func : req0_func;
                    x.tag = g ? req1_tag : req0_tag;
                    x.src = g;
                    if (x.b == 64'd0) begin
                        x.data = ALL1; x.err = 1'b1; zero_chk = 1'b1;
                    end else begin
                        starts_exp++;
                        if (expect_to) begin x.data = ALL1; x.err = 1'b1; end
                        else {x.err, x.data} = ref_div(x.a, x.b, x.f);
                    end
                    sbq.push_back(x);
                    mbusy = 1'b1;
                    ptr = ~g;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit idx, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] f, input logic [TAG_W-1:0] t);
        int n = 0;
        if (!idx) begin
            acc0 = 1'b0; req0_numA = a; req0_numB = b; req0_func = f; req0_tag = t; req0_valid = 1'b1;
        end else begin
            acc1 = 1'b0; req1_numA = a; req1_numB = b; req1_func = f; req1_tag = t; req1_valid = 1'b1;
        end
        while (!(idx ? acc1 : acc0) && n < 300) begin @(posedge clk); #1; n++; end
        chk("accepted", idx ? acc1 : acc0, 1'b1);
        if (!idx) begin req0_valid = 1'b0; acc0 = 1'b0; end
        else begin req1_valid = 1'b0; acc1 = 1'b0; end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mbusy || sbq.size() != 0) && n < 300) begin @(posedge clk); #1; n++; end
        chk("drain", {mbusy, sbq.size() == 0}, 2'b01);
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, "_ctl"}, {resp_valid, req0_ready, req1_ready, div_start, div_clean,
                           resp_err, resp_src, resp_tag, div_func}, 15'd0);
        chk({nm, "_data"}, {resp_data, div_numA, div_numB}, 192'd0);
    endtask

    task automatic gen(output logic [63:0] a, output logic [63:0] b,
                       output logic [1:0] f, output logic [TAG_W-1:0] t);
        int s;
        a = {$urandom, $urandom};
        s = $urandom_range(9, 0);
        if (s == 0) b = 64'd0;
        else if (s < 5) b = 64'($urandom_range(1000, 1)) * (($urandom_range(1, 0) == 0) ? 64'd1 : ALL1);
        else b = {$urandom, $urandom};
        f = 2'($urandom_range(3, 0));
        t = TAG_W'($urandom_range(15, 0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, c0, s0;
        logic [3:0] go;
        rst = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_numA = 64'd0; req0_numB = 64'd0; req0_func = 2'd0; req0_tag = 4'd0;
        req1_valid = 1'b0; req1_numA = 64'd0; req1_numB = 64'd0; req1_func = 2'd0; req1_tag = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // Both valid every cycle, signed remainder -7 rem 2: grants alternate.
        gl.delete();
        req0_numA = 64'hFFFF_FFFF_FFFF_FFF9; req0_numB = 64'd2; req0_func = 2'b11; req0_tag = 4'd5;
        req1_numA = 64'hFFFF_FFFF_FFFF_FFF9; req1_numB = 64'd2; req1_func = 2'b11; req1_tag = 4'd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (gl.size() < 4 && n < 400) begin @(posedge clk); #1; n++; end
        req0_valid = 1'b0; req1_valid = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        go = 4'hF;
        for (int i = 0; i < 4; i++) if (i < gl.size()) go[3-i] = gl[i];
        chk("rr_order", go, 4'b0101);
        wait_idle();
        chk("rem_neg1", last_resp[69:6], ALL1);

        // Unsigned 100/7 quotient from requester 0, tag 3.
        s0 = start_cnt;
        send(1'b0, 64'd100, 64'd7, 2'b00, 4'd3);
        wait_idle();
        chk("q100_7", last_resp, {64'd14, 1'b0, 1'b0, 4'd3});
        chk("one_start", start_cnt - s0, 1);

        // Divide by zero on requester 1.
        s0 = start_cnt;
        send(1'b1, 64'd55, 64'd0, 2'b01, 4'd7);
        wait_idle();
        chk("div0", last_resp, {ALL1, 1'b1, 1'b1, 4'd7});
        chk("div0_no_start", start_cnt - s0, 0);

        // Back-pressure: response held for 10 cycles, then next grant right after handshake.
        resp_ready = 1'b0;
        send(1'b0, 64'd1000, 64'd10, 2'b00, 4'd1);
        n = 0;
        while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
        acc1 = 1'b0; req1_numA = 64'd81; req1_numB = 64'd9; req1_func = 2'b00; req1_tag = 4'd2;
        req1_valid = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("hold_no_grant", acc1, 1'b0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("grant_after_hs", acc1, 1'b1);
        req1_valid = 1'b0; acc1 = 1'b0;
        wait_idle();

        // Watchdog: divider never completes.
        stuck = 1'b1; expect_to = 1'b1;
        c0 = clean_cnt;
        send(1'b0, 64'd77, 64'd5, 2'b00, 4'd2);
        wait_idle();
        chk("to_latency", valid_cyc - start_cyc, TIMEOUT + 1);
        chk("to_clean", clean_cnt - c0, 1);
        chk("to_data", last_resp[69:5], {ALL1, 1'b1});

        // Completion only in the first BUSY cycle must be ignored.
        stuck = 1'b0; lat0 = 1'b1;
        c0 = clean_cnt;
        send(1'b1, 64'd90, 64'd3, 2'b00, 4'd4);
        wait_idle();
        chk("first_busy_ignored", valid_cyc - start_cyc, TIMEOUT + 1);
        chk("first_busy_clean", clean_cnt - c0, 1);
        lat0 = 1'b0;

        // Flush mid-BUSY, then reset mid-BUSY: no responses.
        stuck = 1'b1;
        c0 = clean_cnt;
        send(1'b0, 64'd500, 64'd3, 2'b00, 4'd4);
        repeat (5) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("flush_clean", clean_cnt - c0, 1);
        send(1'b1, 64'd600, 64'd4, 2'b00, 4'd6);
        repeat (5) begin @(posedge clk); #1; end
        req0_valid = 1'b1;
        rst = 1'b0;
        #2;
        check_reset_outs("reset_mid_busy");
        @(negedge clk);
        check_reset_outs("reset_hold");
        req0_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        stuck = 1'b0; expect_to = 1'b0;
        start_cnt = 0; starts_exp = 0;

        // Randomized traffic with back-pressure and occasional flushes.
        for (int c = 0; c < 1500; c++) begin
            if (acc0) begin req0_valid = 1'b0; acc0 = 1'b0; end
            if (acc1) begin req1_valid = 1'b0; acc1 = 1'b0; end
            if (!req0_valid && $urandom_range(2, 0) == 0) begin
                gen(req0_numA, req0_numB, req0_func, req0_tag); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(2, 0) == 0) begin
                gen(req1_numA, req1_numB, req1_func, req1_tag); req1_valid = 1'b1;
            end
            resp_ready = ($urandom_range(3, 0) != 0);
            flush = ($urandom_range(79, 0) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0; resp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("start_count", start_cnt, starts_exp);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/alu_div_share_arbiter.md
ALU_DIV_SHARE_ARBITER -- requirements
Module: alu_div_share_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of requester transaction tag.
REQ-002 SHALL have parameter TIMEOUT, default 31, max BUSY cycles before abort.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset is asynchronous and active-low.
REQ-005 flush  in  1  synchronous abort of queued/in-flight operation.
REQ-006 req0_valid, req1_valid  in  1 each  requester has an operation.
REQ-007 req0_ready, req1_ready  out  1 each  requester's operation accepted this cycle.
REQ-008 req0_numA/numB, req1_numA/numB  in  64 each  dividend/divisor.
REQ-009 req0_func, req1_func  in  2 each  [1]=0 quotient/1 remainder, [0]=0 unsigned/1 signed.
REQ-010 req0_tag, req1_tag  in  TAG_W each  returned unchanged with result.
REQ-011 resp_valid  out  1;  resp_ready  in  1  result handshake.
REQ-012 resp_data  out  64;  resp_err  out  1;  resp_src  out  1 (requester index);  resp_tag  out  TAG_W.
REQ-013 div_start, div_clean  out  1;  div_numA, div_numB  out  64;  div_func  out  2  drive shared divider.
REQ-014 div_numC  in  64;  div_ready  in  1 (divider isNowTickReady);  div_err  in  1.

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, BUSY, HOLD.
REQ-016 IDLE: if any reqN_valid, grant one, assert its reqN_ready for exactly that cycle, latch numA/numB/func/tag/src into operand registers; next state ISSUE (numB!=0) or HOLD (numB==0).
REQ-017 Arbitration SHALL be round-robin: pointer starts at 0; both valid -> grant pointer; after any grant pointer = other index; single valid -> grant it regardless of pointer.
REQ-018 reqN_ready SHALL be 0 in every state except IDLE; at most one ready high per cycle.
REQ-019 div_numA/div_numB/div_func SHALL be driven from operand registers continuously and remain stable from ISSUE until leaving BUSY.
REQ-020 ISSUE: div_start=1 for exactly one cycle; next state BUSY; watchdog counter cleared to 0.
REQ-021 BUSY: div_ready is ignored on the first BUSY cycle; on a later cycle with div_ready=1 latch resp_data=div_numC, resp_err=div_err, go HOLD.
REQ-022 BUSY watchdog increments each cycle; reaching TIMEOUT without div_ready -> div_clean=1 for one cycle, resp_data=64'hFFFF_FFFF_FFFF_FFFF, resp_err=1, go HOLD.
REQ-023 Divisor zero (REQ-016 path): divider not started; resp_data=all ones, resp_err=1.
REQ-024 HOLD: resp_valid=1; resp_data/err/src/tag stable until resp_valid&resp_ready; then IDLE (no new grant same cycle).
REQ-025 flush=1 in any state: next state IDLE, resp_valid=0 next cycle, div_clean=1 for one cycle if state was ISSUE or BUSY, no response for dropped op; flush overrides grant and handshakes in that cycle.
REQ-026 Throughput: one operation in flight; new grant no earlier than cycle after response handshake.

Reset
REQ-027 rst low SHALL immediately force state IDLE, RR pointer 0, watchdog 0, resp_valid 0, req ready 0, div_start 0, div_clean 0, resp_data 0, resp_err 0, resp_src 0, resp_tag 0, operand registers 0.
REQ-028 Reset mid-BUSY SHALL drop the operation with no response; divider is reset by its own rst.

Verification
REQ-029 Req0 unsigned 100/7 quotient, tag 3 -> one div_start pulse; resp_data 14, resp_err 0, resp_src 0, resp_tag 3.
REQ-030 Both valid every cycle, signed remainder -7 rem 2 on both -> grants alternate 0,1,0,1; each resp_data 64'hFFFF_FFFF_FFFF_FFFF (-1).
REQ-031 Req1 numB=0 -> no div_start; resp_valid the cycle after accept, resp_data all ones, resp_err 1.
REQ-032 resp_ready held 0 for 10 cycles in HOLD -> resp outputs stable, no req ready; resp_ready=1 -> IDLE next cycle.
REQ-033 div_ready tied 0 -> after TIMEOUT (31) BUSY cycles one div_clean pulse, resp_err 1, data all ones.
REQ-034 flush mid-BUSY, then rst low mid-BUSY on second op -> no response for either; div_clean pulse on flush; outputs at reset values.
